// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: opcodes, FSM states and
// the ALU control words driven on alu_ctrl (bit k drives Ctrlk).
package alu_seq_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;
    localparam int CNT_W  = 4;
    localparam int CTRL_W = 6;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_OR  = 4'd2,
        OP_NOT = 4'd3,
        OP_XOR = 4'd4,
        OP_AND = 4'd5,
        OP_MOV = 4'd6,
        OP_INC = 4'd7,
        OP_DEC = 4'd8,
        OP_SLA = 4'd9,
        OP_SLL = 4'd10,
        OP_ROL = 4'd11,
        OP_SRA = 4'd12,
        OP_SRL = 4'd13,
        OP_ROR = 4'd14,
        OP_ILL = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Words are tabulated as Ctrl0..Ctrl5 left to right, so each literal here
    // is that string bit-reversed; every shift/rotate word has Ctrl0 set.
    localparam logic [CTRL_W-1:0] CTRL_ADD = 6'b010010;
    localparam logic [CTRL_W-1:0] CTRL_SUB = 6'b100010;
    localparam logic [CTRL_W-1:0] CTRL_OR  = 6'b010100;
    localparam logic [CTRL_W-1:0] CTRL_NOT = 6'b001100;
    localparam logic [CTRL_W-1:0] CTRL_XOR = 6'b011100;
    localparam logic [CTRL_W-1:0] CTRL_AND = 6'b011000;
    localparam logic [CTRL_W-1:0] CTRL_MOV = 6'b000000;
    localparam logic [CTRL_W-1:0] CTRL_INC = 6'b110110;
    localparam logic [CTRL_W-1:0] CTRL_DEC = 6'b000110;
    localparam logic [CTRL_W-1:0] CTRL_SLA = 6'b001001;
    localparam logic [CTRL_W-1:0] CTRL_SLL = 6'b000001;
    localparam logic [CTRL_W-1:0] CTRL_ROL = 6'b010001;
    localparam logic [CTRL_W-1:0] CTRL_SRA = 6'b001101;
    localparam logic [CTRL_W-1:0] CTRL_SRL = 6'b000101;
    localparam logic [CTRL_W-1:0] CTRL_ROR = 6'b010101;

endpackage

// File: rtl/alu_seq_dec.sv
// Combinational opcode decoder: control word, shift/rotate class and
// illegal-opcode flag.
module alu_seq_dec
    import alu_seq_pkg::*;
(
    input  op_e               op_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              is_shift_o,
    output logic              illegal_o
);

    always_comb begin
        ctrl_o     = CTRL_MOV;
        is_shift_o = 1'b0;
        illegal_o  = 1'b0;
        case (op_i)
            OP_ADD: ctrl_o = CTRL_ADD;
            OP_SUB: ctrl_o = CTRL_SUB;
            OP_OR:  ctrl_o = CTRL_OR;
            OP_NOT: ctrl_o = CTRL_NOT;
            OP_XOR: ctrl_o = CTRL_XOR;
            OP_AND: ctrl_o = CTRL_AND;
            OP_MOV: ctrl_o = CTRL_MOV;
            OP_INC: ctrl_o = CTRL_INC;
            OP_DEC: ctrl_o = CTRL_DEC;
            OP_SLA: begin ctrl_o = CTRL_SLA; is_shift_o = 1'b1; end
            OP_SLL: begin ctrl_o = CTRL_SLL; is_shift_o = 1'b1; end
            OP_ROL: begin ctrl_o = CTRL_ROL; is_shift_o = 1'b1; end
            OP_SRA: begin ctrl_o = CTRL_SRA; is_shift_o = 1'b1; end
            OP_SRL: begin ctrl_o = CTRL_SRL; is_shift_o = 1'b1; end
            OP_ROR: begin ctrl_o = CTRL_ROR; is_shift_o = 1'b1; end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Request/response sequencer that drives an external combinational ALU for
// one step (logic/arith ops) or cnt steps (shift/rotate ops).
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_cin,
    input  logic [CNT_W-1:0]  req_cnt,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_y,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic              rsp_c,
    output logic              rsp_z,
    output logic              rsp_err
);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   work_q, work_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                carry_q, carry_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [CTRL_W-1:0]   dec_ctrl;
    logic                dec_shift;
    logic                dec_illegal;

    alu_seq_dec u_dec (
        .op_i       (op_e'(req_op)),
        .ctrl_o     (dec_ctrl),
        .is_shift_o (dec_shift),
        .illegal_o  (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            ctrl_q  <= '0;
            work_q  <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            work_q  <= work_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctrl_d  = ctrl_q;
        work_d  = work_q;
        b_d     = b_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = op_e'(req_op);
                    ctrl_d = dec_ctrl;
                    b_d    = req_b;
                    if (dec_illegal) begin
                        work_d  = '0;
                        carry_d = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_RESP;
                    end else begin
                        work_d  = req_a;
                        carry_d = req_cin;
                        // Non-shift ops always run a single ALU step.
                        cnt_d   = dec_shift ? req_cnt : CNT_W'(1);
                        state_d = (dec_shift && req_cnt == '0) ? ST_RESP : ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                work_d  = alu_y;
                carry_d = alu_cout;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        // Gated by rst_n so that ready stays low for the whole reset pulse.
        req_ready = rst_n && (state_q == ST_IDLE);
        alu_ctrl  = CTRL_MOV;
        alu_a     = '0;
        alu_b     = '0;
        alu_cin   = 1'b0;
        rsp_valid = 1'b0;
        rsp_y     = '0;
        rsp_c     = 1'b0;
        rsp_z     = 1'b0;
        rsp_err   = 1'b0;
        if (state_q == ST_EXEC) begin
            alu_ctrl = ctrl_q;
            alu_a    = work_q;
            alu_b    = b_q;
            alu_cin  = carry_q;
        end
        if (state_q == ST_RESP) begin
            rsp_valid = 1'b1;
            rsp_y     = work_q;
            rsp_c     = carry_q;
            rsp_z     = (work_q == '0);
            rsp_err   = (op_q == OP_ILL);
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU attached to the alu_* bus.
module tb_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin;
    logic [3:0]  req_cnt;
    logic [5:0]  alu_ctrl;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_cin;
    logic [15:0] alu_y;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_y;
    logic        rsp_c;
    logic        rsp_z;
    logic        rsp_err;

    int n_vec = 0;
    int n_err = 0;
    int lat;
    logic [16:0] tmp;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_cnt   (req_cnt),
        .alu_ctrl  (alu_ctrl),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_c     (rsp_c),
        .rsp_z     (rsp_z),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Converts a control word written Ctrl0..Ctrl5 left to right into bus order.
    function automatic logic [5:0] cw(input logic [5:0] listed);
        logic [5:0] r;
        for (int k = 0; k < 6; k++) r[k] = listed[5-k];
        return r;
    endfunction

    // Behavioural ALU keyed on the tabulated control strings.
    always_comb begin
        tmp      = '0;
        alu_y    = '0;
        alu_cout = 1'b0;
        case (cw(alu_ctrl))
            6'b010010: tmp = {1'b0, alu_a} + {1'b0, alu_b} + {16'd0, alu_cin};
            6'b010001: tmp = {1'b0, alu_a} - {1'b0, alu_b} - {16'd0, alu_cin};
            6'b001010: tmp = {1'b0, alu_a | alu_b};
            6'b001100: tmp = {1'b0, ~alu_a};
            6'b001110: tmp = {1'b0, alu_a ^ alu_b};
            6'b000110: tmp = {1'b0, alu_a & alu_b};
            6'b011011: tmp = {1'b0, alu_a} + 17'd1;
            6'b011000: tmp = {1'b0, alu_a} - 17'd1;
            6'b100100: tmp = {alu_a[15], alu_a[14:0], 1'b0};
            6'b100000: tmp = {alu_a[15], alu_a[14:0], 1'b0};
            6'b100010: tmp = {alu_a[15], alu_a[14:0], alu_a[15]};
            6'b101100: tmp = {alu_a[0], alu_a[15], alu_a[15:1]};
            6'b101000: tmp = {alu_a[0], 1'b0, alu_a[15:1]};
            6'b101010: tmp = {alu_a[0], alu_a[0], alu_a[15:1]};
            default:   tmp = {1'b0, alu_a};
        endcase
        alu_y    = tmp[15:0];
        alu_cout = tmp[16];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [3:0] cnt);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        req_cnt   = cnt;
        chk("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int max, output int l);
        l = 1;
        while (rsp_valid !== 1'b1 && l < max) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic close_rsp(input string tag);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_y_cleared"}, {16'd0, rsp_y}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic cin, input logic [3:0] cnt,
                       input int exp_lat, input logic [15:0] exp_y, input logic exp_c,
                       input logic exp_z, input logic exp_err);
        int l;
        issue(op, a, b, cin, cnt);
        wait_rsp(40, l);
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_y"}, {16'd0, rsp_y}, {16'd0, exp_y});
        chk({tag, "_c"}, {31'd0, rsp_c}, {31'd0, exp_c});
        chk({tag, "_z"}, {31'd0, rsp_z}, {31'd0, exp_z});
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        close_rsp(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        req_cnt   = '0;
        rsp_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu_ctrl", {26'd0, alu_ctrl}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // ADD with EXEC-cycle bus check
        issue(4'd0, 16'h7FFF, 16'h0001, 1'b0, 4'd3);
        chk("add_ctrl", {26'd0, alu_ctrl}, {26'd0, cw(6'b010010)});
        chk("add_alu_a", {16'd0, alu_a}, 32'h7FFF);
        chk("add_alu_b", {16'd0, alu_b}, 32'h0001);
        chk("add_alu_cin", {31'd0, alu_cin}, 32'd0);
        chk("add_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        chk("add_busy", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("add_valid_lat2", {31'd0, rsp_valid}, 32'd1);
        chk("add_y", {16'd0, rsp_y}, 32'h8000);
        chk("add_c", {31'd0, rsp_c}, 32'd0);
        chk("add_z", {31'd0, rsp_z}, 32'd0);
        chk("add_alu_idle", {26'd0, alu_ctrl}, 32'd0);
        close_rsp("add");

        // SLL cnt=4: one EXEC cycle per step
        issue(4'd10, 16'h0001, 16'h0000, 1'b0, 4'd4);
        for (int i = 0; i < 4; i++) begin
            chk("sll_ctrl", {26'd0, alu_ctrl}, {26'd0, cw(6'b100000)});
            chk("sll_alu_a", {16'd0, alu_a}, 32'd1 << i);
            chk("sll_no_rsp", {31'd0, rsp_valid}, 32'd0);
            @(negedge clk);
        end
        chk("sll_valid", {31'd0, rsp_valid}, 32'd1);
        chk("sll_y", {16'd0, rsp_y}, 32'h0010);
        chk("sll_alu_idle", {26'd0, alu_ctrl}, 32'd0);
        close_rsp("sll");

        // ROR cnt=0 bypasses the ALU
        issue(4'd14, 16'h1234, 16'h5555, 1'b1, 4'd0);
        chk("ror0_valid_lat1", {31'd0, rsp_valid}, 32'd1);
        chk("ror0_y", {16'd0, rsp_y}, 32'h1234);
        chk("ror0_c", {31'd0, rsp_c}, 32'd1);
        chk("ror0_ctrl", {26'd0, alu_ctrl}, 32'd0);
        close_rsp("ror0");

        // Illegal opcode
        issue(4'd15, 16'hFFFF, 16'h0001, 1'b1, 4'd2);
        chk("ill_valid_lat1", {31'd0, rsp_valid}, 32'd1);
        chk("ill_err", {31'd0, rsp_err}, 32'd1);
        chk("ill_y", {16'd0, rsp_y}, 32'd0);
        chk("ill_z", {31'd0, rsp_z}, 32'd1);
        chk("ill_c", {31'd0, rsp_c}, 32'd0);
        chk("ill_alu_a", {16'd0, alu_a}, 32'd0);
        chk("ill_ctrl", {26'd0, alu_ctrl}, 32'd0);
        close_rsp("ill");

        // SUB to zero with back-pressure
        issue(4'd1, 16'h00AA, 16'h00AA, 1'b0, 4'd0);
        chk("sub_ctrl", {26'd0, alu_ctrl}, {26'd0, cw(6'b010001)});
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("sub_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("sub_hold_y", {16'd0, rsp_y}, 32'h0000);
            chk("sub_hold_z", {31'd0, rsp_z}, 32'd1);
            chk("sub_hold_ready", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
        end
        close_rsp("sub");

        // Further directed ops
        run("srl3",  4'd13, 16'h8001, 16'h0000, 1'b0, 4'd3,  4,  16'h1000, 1'b0, 1'b0, 1'b0);
        run("rol1",  4'd11, 16'h8001, 16'h0000, 1'b0, 4'd1,  2,  16'h0003, 1'b1, 1'b0, 1'b0);
        run("inc",   4'd7,  16'hFFFF, 16'h0000, 1'b0, 4'd0,  2,  16'h0000, 1'b1, 1'b1, 1'b0);
        run("xor",   4'd4,  16'hF0F0, 16'hFF00, 1'b0, 4'd0,  2,  16'h0FF0, 1'b0, 1'b0, 1'b0);
        run("movcnt",4'd6,  16'hBEEF, 16'h1111, 1'b0, 4'd5,  2,  16'hBEEF, 1'b0, 1'b0, 1'b0);
        run("sll15", 4'd10, 16'h0001, 16'h0000, 1'b0, 4'd15, 16, 16'h8000, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a long SRA
        issue(4'd12, 16'h8000, 16'h0000, 1'b0, 4'd8);
        @(negedge clk);
        @(negedge clk);
        chk("sra_running", {26'd0, alu_ctrl}, {26'd0, cw(6'b101100)});
        rst_n = 1'b0;
        #1;
        chk("sra_rst_ctrl", {26'd0, alu_ctrl}, 32'd0);
        chk("sra_rst_alu_a", {16'd0, alu_a}, 32'd0);
        chk("sra_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("sra_rst_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen = 1'b1;
        end
        chk("sra_aborted_no_rsp", {31'd0, seen}, 32'd0);
        run("add_after_rst", 4'd0, 16'h1234, 16'h1111, 1'b1, 4'd0, 2, 16'h2346, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset.
REQ-003 req_valid  in  1  operation request present.
REQ-004 req_ready  out  1  sequencer can accept a request.
REQ-005 req_op  in  4  opcode 0..14: ADD, SUB, OR, NOT, XOR, AND, MOV, INC, DEC, SLA, SLL, ROL, SRA, SRL, ROR; 15 illegal.
REQ-006 req_a, req_b  in  16 each  operands.
REQ-007 req_cin  in  1  carry-in for the first ALU step.
REQ-008 req_cnt  in  4  step count for shift/rotate opcodes 9..14; ignored otherwise.
REQ-009 alu_ctrl  out  6  ALU control lines; bit k drives Ctrlk.
REQ-010 alu_a, alu_b  out  16 each  ALU operands.
REQ-011 alu_cin  out  1  drives ALU c_flag.
REQ-012 alu_y  in  16; alu_cout  in  1  combinational ALU result and carry, valid in the same cycle.
REQ-013 rsp_valid  out  1; rsp_ready  in  1  response handshake.
REQ-014 rsp_y  out  16; rsp_c, rsp_z, rsp_err  out  1 each  result, carry, zero, illegal-op.

Function
REQ-015 Ctrl0..Ctrl5 words SHALL be: ADD 010010, SUB 010001, OR 001010, NOT 001100, XOR 001110, AND 000110, MOV 000000, INC 011011, DEC 011000, SLA 100100, SLL 100000, ROL 100010, SRA 101100, SRL 101000, ROR 101010.
REQ-016 FSM states SHALL be IDLE, EXEC, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1.
REQ-018 On accept, op, a, b, cin and cnt SHALL be registered; legal non-shift ops and shift ops with cnt>0 go to EXEC. Illegal ops and shift ops with cnt=0 go directly to RESP.
REQ-019 In EXEC, alu_ctrl SHALL be the op word, alu_a the working value (initially req_a), alu_b the registered b, and alu_cin the working carry (initially req_cin).
REQ-020 Each EXEC cycle SHALL capture alu_y into the working value and alu_cout into the working carry, then decrement the remaining count.
REQ-021 Non-shift ops SHALL take exactly one EXEC cycle; shift ops SHALL take exactly cnt EXEC cycles, then go to RESP.
REQ-022 Latency SHALL be cnt+1 cycles from the accept edge to rsp_valid=1 for shift ops (2 cycles for non-shift ops, 1 for cnt=0 or illegal).
REQ-023 In RESP: rsp_valid=1; rsp_y = working value; rsp_c = working carry; rsp_z = (rsp_y==0); rsp_err = (op==15).
REQ-024 Shift with cnt=0: rsp_y=req_a, rsp_c=req_cin, no ALU step. Illegal op: rsp_y=0, rsp_c=0, rsp_err=1, no ALU step.
REQ-025 RESP SHALL hold all rsp_* outputs stable until rsp_ready=1, then return to IDLE; no new request is accepted in that same cycle.
REQ-026 Outside EXEC: alu_ctrl=000000 (MOV), alu_a=alu_b=0, alu_cin=0.
REQ-027 rsp_valid SHALL be 0 and rsp_* outputs SHALL be 0 outside RESP.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, clear all registers and outputs to 0, and set req_ready=1 once released.
REQ-029 Reset during EXEC or RESP SHALL abort the operation with no response produced.

Structure
REQ-030 Package alu_seq_pkg SHALL hold the opcode enum, the 15 ctrl-word constants, the FSM state enum and the operand width (16).
REQ-031 Sub-module alu_seq_dec SHALL map opcode to {ctrl word, is_shift, illegal} combinationally.
REQ-032 The target size is 120-400 RTL lines; no ALU logic is included in alu_seq.

Verification
REQ-033 ADD a=0x7FFF, b=0x0001, cin=0 (bench ALU model) -> rsp_valid 2 cycles after accept, rsp_y=0x8000, rsp_c=0, rsp_z=0; alu_ctrl=010010 during EXEC.
REQ-034 SLL a=0x0001, cnt=4 -> exactly 4 EXEC cycles with alu_a 0x0001, 0x0002, 0x0004, 0x0008; then rsp_y=0x0010.
REQ-035 ROR a=0x1234, cnt=0 -> rsp_valid 1 cycle after accept, rsp_y=0x1234, alu_ctrl stays 000000.
REQ-036 op=15 -> rsp_err=1, rsp_y=0, rsp_z=1; the ALU is never driven.
REQ-037 SUB a=b=0x00AA with rsp_ready held low for 5 cycles -> rsp_y=0x0000 and rsp_z=1 held stable; req_ready=0 until the handshake.
REQ-038 rst_n pulsed low mid-way through an SRA with cnt=8 -> outputs 0 immediately, no rsp_valid, and the next request is accepted normally.
